// File: rtl/shift_seq_arbiter.sv
// ---------------------------------------------------------------------------
// shift_seq_arbiter
//
// One iterative shifter shared by two issue lanes. A request is granted in
// IDLE (round-robin on ties), then the operand is shifted by 8, 4, 2 or 1 bits
// per cycle, always taking the largest stage that still fits the remaining
// amount. The result is held in DONE until the consumer takes it.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   req0_valid   lane 0 request
//   req0_ready   lane 0 request accepted this cycle (combinational)
//   req0_op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   req0_data    lane 0 operand
//   req0_amt     lane 0 shift amount
//   req1_*       same set for lane 1
//   res_valid    result available (DONE state)
//   res_ready    consumer takes the result
//   res_data     shifted result (zero while res_valid is low)
//   res_lane     lane that issued the result (zero while res_valid is low)
//   busy         high in SHIFT and DONE
// ---------------------------------------------------------------------------
module shift_seq_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [1:0]         req0_op,
  input  logic [WIDTH-1:0]   req0_data,
  input  logic [SHAMT_W-1:0] req0_amt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [1:0]         req1_op,
  input  logic [WIDTH-1:0]   req1_data,
  input  logic [SHAMT_W-1:0] req1_amt,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   res_data,
  output logic               res_lane,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t               state_reg, state_next;
  logic                 last_grant_reg, last_grant_next;
  logic [1:0]           op_reg, op_next;
  logic [WIDTH-1:0]     work_reg, work_next;
  logic [SHAMT_W-1:0]   rem_reg, rem_next;
  logic                 lane_reg, lane_next;

  // ---------------------------------------------------------------------
  // Arbitration: a lone requester wins; on a tie the lane that did not win
  // last time is chosen.
  // ---------------------------------------------------------------------
  logic grant_any;
  logic grant_lane;
  logic accept;

  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_lane = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_lane = ~last_grant_reg;
    end else begin
      grant_lane = req1_valid;
    end
  end

  assign accept     = (state_reg == IDLE) && grant_any;
  assign req0_ready = accept && !grant_lane;
  assign req1_ready = accept &&  grant_lane;

  // ---------------------------------------------------------------------
  // Fixed-distance stage candidates: stage gi shifts by 2**gi bits.
  // Only the one matching the current step is used each cycle.
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] stage_out [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_stage
      localparam int S = 1 << gi;
      logic [WIDTH-1:0] sll_v;
      logic [WIDTH-1:0] srl_v;
      logic [WIDTH-1:0] sra_v;
      logic [WIDTH-1:0] ror_v;

      assign sll_v = {work_reg[WIDTH-1-S:0], {S{1'b0}}};
      assign srl_v = {{S{1'b0}}, work_reg[WIDTH-1:S]};
      // Replicating the current MSB keeps the sign across successive steps.
      assign sra_v = {{S{work_reg[WIDTH-1]}}, work_reg[WIDTH-1:S]};
      assign ror_v = {work_reg[S-1:0], work_reg[WIDTH-1:S]};

      assign stage_out[gi] = (op_reg == OP_SLL) ? sll_v :
                             (op_reg == OP_SRL) ? srl_v :
                             (op_reg == OP_SRA) ? sra_v : ror_v;
    end
  endgenerate

  // Greedy step choice from the remaining amount.
  logic [1:0]         step_idx;
  logic [SHAMT_W-1:0] step_amt;

  always_comb begin
    if (rem_reg >= SHAMT_W'(8)) begin
      step_idx = 2'd3;
    end else if (rem_reg >= SHAMT_W'(4)) begin
      step_idx = 2'd2;
    end else if (rem_reg >= SHAMT_W'(2)) begin
      step_idx = 2'd1;
    end else begin
      step_idx = 2'd0;
    end
  end

  assign step_amt = SHAMT_W'(1) << step_idx;

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    op_next         = op_reg;
    work_next       = work_reg;
    rem_next        = rem_reg;
    lane_next       = lane_reg;

    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          // Operands are captured only here; later input changes are ignored.
          lane_next       = grant_lane;
          last_grant_next = grant_lane;
          if (grant_lane) begin
            op_next   = req1_op;
            work_next = req1_data;
            rem_next  = req1_amt;
          end else begin
            op_next   = req0_op;
            work_next = req0_data;
            rem_next  = req0_amt;
          end
          state_next = (rem_next != '0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        work_next = stage_out[step_idx];
        rem_next  = rem_reg - step_amt;
        if (rem_reg == step_amt) begin
          state_next = DONE;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;  // lane 0 wins the first tie
      op_reg         <= '0;
      work_reg       <= '0;
      rem_reg        <= '0;
      lane_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      op_reg         <= op_next;
      work_reg       <= work_next;
      rem_reg        <= rem_next;
      lane_reg       <= lane_next;
    end
  end

  // Outputs decode straight from the state register so reset clears them
  // without waiting for a clock edge.
  assign res_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign res_data  = res_valid ? work_reg : '0;
  assign res_lane  = res_valid & lane_reg;

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_arbiter
//
// Directed stimulus with hand-computed results. Each accepted request pushes
// its expected result and due cycle into a scoreboard; a monitor process pops
// and compares whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_shift_seq_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [1:0]  req0_op;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready;
  logic [1:0]  req1_op;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_lane;
  logic        busy;

  shift_seq_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_lane   (res_lane),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          lane;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Monitor: samples 4 time units after the falling edge.
  // ---------------------------------------------------------------------
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    #4;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (res_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: actual lane=%0d data=%h required none", res_lane, res_data);
        end else begin
          if (!prev_valid) chk("latency_cycle", cyc, sb[0].due);
          if (res_ready) begin
            chk("res_data", res_data, sb[0].data);
            chk("res_lane", res_lane, sb[0].lane);
            $display("result lane=%0d data=%h expected lane=%0d data=%h cycle=%0d",
                     res_lane, res_data, sb[0].lane, sb[0].data, cyc);
            void'(sb.pop_front());
          end else begin
            chk("hold_data", res_data, sb[0].data);
            chk("hold_lane", res_lane, sb[0].lane);
          end
        end
      end
      prev_valid = res_valid && !res_ready;
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic drive(input bit lane, input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] amt);
    if (lane) begin
      req1_op = op; req1_data = d; req1_amt = amt; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_data = d; req0_amt = amt; req0_valid = 1'b1;
    end
  endtask

  // Wait for the lane to be accepted; k is the hand-counted number of steps.
  task automatic wait_accept(input bit lane, input logic [31:0] exp_v, input int k);
    bit got = 1'b0;
    for (int t = 0; t < 80 && !got; t++) begin
      #1;
      if (lane ? req1_ready : req0_ready) begin
        got = 1'b1;
        sb.push_back('{lane, exp_v, cyc + k + 1});
      end
      @(negedge clk);
    end
    if (lane) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: actual no grant required grant on lane %0d", lane);
    end
  endtask

  task automatic issue(input bit lane, input logic [1:0] op, input logic [31:0] d,
                       input logic [4:0] amt, input logic [31:0] exp_v, input int k);
    drive(lane, op, d, amt);
    wait_accept(lane, exp_v, k);
  endtask

  task automatic wait_idle();
    bit got = 1'b0;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      #1;
      if (!busy && sb.size() == 0) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: actual busy=%0d pending=%0d required idle", busy, sb.size());
    end
  endtask

  task automatic wait_res();
    bit got = 1'b0;
    for (int t = 0; t < 80 && !got; t++) begin
      #1;
      if (res_valid) got = 1'b1;
      else @(negedge clk);
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: actual res_valid=0 required 1");
    end
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    res_ready = 1'b1;
    req0_valid = 1'b0; req0_op = 2'b00; req0_data = '0; req0_amt = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_data = '0; req1_amt = '0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_data", res_data, 32'h0);
    chk("rst_res_lane", res_lane, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Tie from reset: lane 0 first, then lane 1, then a further tie to lane 0
    drive(1'b0, 2'b00, 32'h0000_0001, 5'd4);
    drive(1'b1, 2'b11, 32'h0000_0001, 5'd8);
    #1;
    chk("tie1_req0_ready", req0_ready, 1'b1);
    chk("tie1_req1_ready", req1_ready, 1'b0);
    wait_accept(1'b0, 32'h0000_0010, 1);
    wait_accept(1'b1, 32'h0100_0000, 1);
    wait_idle();

    drive(1'b0, 2'b11, 32'h1234_5678, 5'd12);
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 5'd31);
    #1;
    chk("tie2_req0_ready", req0_ready, 1'b1);
    chk("tie2_req1_ready", req1_ready, 1'b0);
    wait_accept(1'b0, 32'h6781_2345, 2);
    wait_accept(1'b1, 32'h8000_0000, 6);
    wait_idle();

    // Single-lane vectors
    issue(1'b0, 2'b10, 32'h8000_0000, 5'd13, 32'hFFFC_0000, 3);
    issue(1'b1, 2'b01, 32'hF000_0000, 5'd31, 32'h0000_0001, 6);
    issue(1'b0, 2'b10, 32'h1234_5678, 5'd0,  32'h1234_5678, 0);
    issue(1'b1, 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003, 6);
    wait_idle();

    // Back-pressure: result held, no grants while DONE
    res_ready = 1'b0;
    issue(1'b0, 2'b10, 32'h7FFF_FFFF, 5'd3, 32'h0FFF_FFFF, 2);
    drive(1'b1, 2'b01, 32'h8000_0000, 5'd1);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      chk("hold_req0_ready", req0_ready, 1'b0);
      chk("hold_req1_ready", req1_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
      @(negedge clk);
      #1;
    end
    res_ready = 1'b1;
    wait_accept(1'b1, 32'h4000_0000, 1);
    wait_idle();

    // Asynchronous reset in the middle of SHIFT
    issue(1'b0, 2'b10, 32'h8000_0000, 5'd20, 32'hFFFF_F800, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_res_valid", res_valid, 1'b0);
    chk("arst_res_data", res_data, 32'h0);
    chk("arst_res_lane", res_lane, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_res_valid", res_valid, 1'b0);
      @(negedge clk);
    end
    drive(1'b0, 2'b00, 32'h0000_0003, 5'd2);
    drive(1'b1, 2'b10, 32'h8000_0000, 5'd1);
    #1;
    chk("tie3_req0_ready", req0_ready, 1'b1);
    chk("tie3_req1_ready", req1_ready, 1'b0);
    wait_accept(1'b0, 32'h0000_000C, 1);
    wait_accept(1'b1, 32'hC000_0000, 1);
    wait_idle();

    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: actual pending=%0d required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_arbiter.md
Name: shift_seq_arbiter

Overview:
Multi-cycle shift sequencer shared by the two issue lanes of the 2-wide processor. It arbitrates between the lanes' shift requests and computes each result iteratively: one shift stage of 8, 4, 2 or 1 bits is applied per cycle, chosen greedily from the remaining amount. It supports SLL, SRL, SRA and ROR, and returns each result with a lane tag over a valid/ready handshake. It replaces two full barrel shifters with one sequenced datapath.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
SHAMT_W, 5, shift-amount width.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req0_valid  input  1  lane 0 shift request
req0_ready  output  1  lane 0 request accepted this cycle
req0_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
req0_data  input  WIDTH  operand
req0_amt  input  SHAMT_W  shift amount
req1_valid/req1_ready/req1_op/req1_data/req1_amt  same as lane 0, for lane 1
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_data  output  WIDTH  shifted result
res_lane  output  1  lane that issued the result
busy  output  1  high in any non-IDLE state

Behaviour:
- Reset (async, any state): state=IDLE, res_valid=0, res_data=0, res_lane=0, busy=0, last_grant=1 (so lane 0 wins the first tie). Any in-flight operation is dropped with no result.
- States: IDLE, SHIFT, DONE.
- IDLE grant:
  - Only one lane valid: that lane is granted.
  - Both lanes valid: the lane other than last_grant is granted (round-robin).
  - reqN_ready is combinational and high only in IDLE for the granted lane; at most one ready is high per cycle.
  - On acceptance: latch op, data, amt (as rem) and lane; update last_grant.
  - Next state is SHIFT if amt!=0, otherwise DONE.
- SHIFT, one step per cycle:
  - Step size: 8 if rem>=8; else 4 if rem>=4; else 2 if rem>=2; else 1.
  - Apply the step to the working register; rem -= step.
  - When rem reaches 0 at this edge, go to DONE.
- Step semantics:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with working bit 31 (sign is preserved across steps).
  - ROR: bits shifted out at LSB re-enter at MSB.
- Latency: the acceptance cycle is cycle 0. For k = number of steps (0..6; amt=31 gives 8,8,8,4,2,1), res_valid is first high in cycle k+1.
- DONE:
  - res_valid=1; res_data and res_lane are stable while res_valid=1 and res_ready=0.
  - On res_valid&&res_ready the next state is IDLE. No request is accepted in the DONE cycle, so back-to-back throughput is one result per k+2 cycles.
- busy is high in SHIFT and DONE; requests are not accepted while busy.
- A requester may drop valid before acceptance without effect. Once accepted, the operation completes regardless of the requester's valid.
- Inputs are sampled only at acceptance; later changes to op/data/amt do not affect the in-flight operation.
- No overflow or flag outputs; amounts are fully covered by the 5-bit range.

Test Plan:
1. Lane 0 SRA, data=0x80000000, amt=13 -> steps 8,4,1; res_valid in cycle 4; res_data=0xFFFC0000; res_lane=0.
2. Lane 1 SRL, data=0xF0000000, amt=31 -> 6 steps; res_valid in cycle 7; res_data=0x00000001; res_lane=1.
3. Both lanes valid from reset: lane0 SLL 0x1 by 4, lane1 ROR 0x00000001 by 8 -> lane 0 granted first, result 0x00000010. Lane 1 is granted in the first IDLE cycle after the handshake, result 0x01000000, res_lane=1. A further tie goes to lane 0.
4. amt=0, SRA, data=0x12345678 -> no SHIFT state; res_valid in cycle 1; res_data=0x12345678.
5. res_ready held low for 5 cycles in DONE -> res_valid, res_data and res_lane stay constant. Both reqN_ready stay 0 throughout. Only when res_ready rises does the block return to IDLE.
6. Assert rst during SHIFT (lane0 SRA 0x80000000 by 20) -> outputs return to reset values immediately (before the next edge). No result is produced; after rst deasserts, lane 0 wins the next tie.
